peri_rx: RTL
============

PERI_RX -- requirements
Module: peri_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter END_ADDR, default 16'hFFFF, address whose write signals end of program output.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port peri_web  input  1  write strobe, active-low, one write per low cycle.
REQ-006 SHALL have port peri_addr  input  16  write address, valid while peri_web low.
REQ-007 SHALL have port peri_datao  input  16  write data, valid while peri_web low.
REQ-008 SHALL have port out_valid  output  1  FIFO head available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head.
REQ-010 SHALL have port out_addr  output  16  head entry address.
REQ-011 SHALL have port out_data  output  16  head entry data.
REQ-012 SHALL have port level  output  7  current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky; a write was dropped while full.
REQ-014 SHALL have port done  output  1  END_ADDR received and FIFO drained.

Function
REQ-015 SHALL capture a write on each rising edge where peri_web==0; no backpressure to the writer exists.
REQ-016 SHALL enqueue {peri_addr, peri_datao} when the address is not END_ADDR, the FIFO is not full, and the state is IDLE or ACTIVE.
REQ-017 SHALL drop a non-END_ADDR write arriving while full (level==DEPTH with no simultaneous pop) and set overflow in the same edge.
REQ-018 SHALL accept a push when full if a pop occurs on the same edge; level stays DEPTH and overflow is not set.
REQ-019 SHALL pop on an edge where out_valid && out_ready; out_valid = (level!=0); out_addr/out_data show the head entry directly from storage, with zero added latency.
REQ-020 SHALL make an enqueued entry visible on out_valid the cycle after capture; a push into an empty FIFO is never bypassed to the output in the same cycle.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH; simultaneous push and pop leaves level unchanged.
REQ-022 SHALL use FSM states IDLE, ACTIVE, DRAIN, DONE.
REQ-023 SHALL transition IDLE->ACTIVE on the first accepted non-END write.
REQ-024 SHALL transition IDLE/ACTIVE->DRAIN on a write to END_ADDR; END_ADDR writes are never enqueued.
REQ-025 SHALL transition DRAIN->DONE when level reaches 0, including an END_ADDR write while empty, which reaches DONE on the next edge.
REQ-026 SHALL ignore all writes in DRAIN and DONE: no enqueue, no overflow; DONE is held until reset.
REQ-027 SHALL drive done=1 only in state DONE.

Reset
REQ-028 SHALL, on rst_n low, immediately clear pointers, level=0, out_valid=0, overflow=0, done=0, state=IDLE; out_addr/out_data=0.
REQ-029 SHALL discard FIFO contents when reset asserts mid-operation, and accept writes on the first edge after deassertion.

Configuration
REQ-030 SHALL, when PERI_RX_DROP_CNT_EN is defined, add output port drop_cnt (8 bits), reset to 0, incremented per dropped write (REQ-017) and saturating at 255.
REQ-031 SHALL, when PERI_RX_DROP_CNT_EN is undefined, omit drop_cnt and its logic entirely; all other behaviour is identical.

Verification
REQ-032 SHALL verify: 3 writes (0x0010/0x1111, 0x0011/0x2222, 0x0012/0x3333) with out_ready=1 -> out_valid each cycle after capture; same order; level never exceeds 1; overflow=0.
REQ-033 SHALL verify: out_ready=0, 10 writes at DEPTH=8 -> level=8, entries 9-10 dropped, overflow=1, drop_cnt=2 (macro on); then draining yields exactly the first 8 entries.
REQ-034 SHALL verify: full FIFO, a write and out_ready=1 on the same edge -> write accepted, level stays 8, overflow stays 0.
REQ-035 SHALL verify: 2 queued entries, write to 0xFFFF, then another write to 0x0020 -> 0x0020 ignored; done=1 the edge after the 2nd pop.
REQ-036 SHALL verify: rst_n low for 1 cycle with 5 entries queued -> level=0, out_valid=0, state IDLE immediately; a write the next edge shows out_valid=1 one cycle later.
REQ-037 SHALL verify: out_ready=0 with 300 writes, macro on -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/peri_rx.sv
// Peripheral write receiver: captures strobed address/data writes into a FIFO until END_ADDR is written.
// Optional feature macro: PERI_RX_DROP_CNT_EN adds a saturating dropped-write counter output drop_cnt.
module peri_rx #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] END_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        peri_web,
  input  logic [15:0] peri_addr,
  input  logic [15:0] peri_datao,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [15:0] out_data,
  output logic [6:0]  level,
  output logic        overflow,
  output logic        done
`ifdef PERI_RX_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     head;

  logic wr;
  logic is_end;
  logic accepting;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign wr        = ~peri_web;
  assign is_end    = (peri_addr == END_ADDR);
  assign accepting = (state == IDLE) || (state == ACTIVE);
  assign full      = (level == 7'(DEPTH));
  assign out_valid = (level != 7'd0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign push      = wr & ~is_end & accepting & (~full | pop);
  assign drop      = wr & ~is_end & accepting & full & ~pop;

  // Head is read straight from storage; forced to zero when nothing is queued
  // so the outputs read as zero right after reset without clearing storage.
  assign head     = mem[rd_ptr];
  assign out_addr = out_valid ? head[31:16] : 16'h0000;
  assign out_data = out_valid ? head[15:0]  : 16'h0000;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {peri_addr, peri_datao};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= 7'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 7'd1;
        2'b01:   level <= level - 7'd1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (wr && is_end)  state <= DRAIN;
          else if (push)     state <= ACTIVE;
        end
        ACTIVE: begin
          if (wr && is_end)  state <= DRAIN;
        end
        DRAIN: begin
          if (level == 7'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
          done  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERI_RX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule
